// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: fetch/decode/memory/writeback handshakes
// with a per-state timeout, sticky halt/error flags and 64-bit activity counters.
module core_seq #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  inst_opcode,
    input  logic [2:0]  read_mem,
    input  logic [1:0]  write_mem,
    input  logic        write_reg,
    output logic        ifu_req,
    input  logic        ifu_gnt,
    input  logic        ifu_rvalid,
    output logic        ir_we,
    output logic        lsu_req,
    output logic        lsu_wr,
    input  logic        lsu_gnt,
    input  logic        lsu_rvalid,
    output logic        rf_we,
    output logic        pc_we,
    output logic        halted,
    output logic        error,
    output logic [3:0]  state,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret
);

    localparam int unsigned TW = 8;
    localparam int unsigned CW = 64;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_WAIT_I = 4'd2,
        S_DECODE = 4'd3,
        S_MEM    = 4'd4,
        S_WAIT_D = 4'd5,
        S_WB     = 4'd6,
        S_HALT   = 4'd7,
        S_ERROR  = 4'd8
    } state_t;

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t        cur_state;
    state_t        nxt_state;
    logic [TW-1:0] tmo;
    logic          retire;
    logic          opcode_ok;
    logic          in_wait;
    logic          active;

    always_comb begin
        opcode_ok = 1'b0;
        case (inst_opcode)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: opcode_ok = 1'b1;
            default: opcode_ok = 1'b0;
        endcase
    end

    assign in_wait = (cur_state == S_FETCH) || (cur_state == S_WAIT_I) ||
                     (cur_state == S_MEM)   || (cur_state == S_WAIT_D);
    assign active  = (cur_state != S_IDLE) && (cur_state != S_HALT) &&
                     (cur_state != S_ERROR);
    assign state   = cur_state;

    // Next-state and strobe decode; a handshake in the timeout cycle wins.
    always_comb begin
        nxt_state = cur_state;
        ifu_req   = 1'b0;
        ir_we     = 1'b0;
        lsu_req   = 1'b0;
        lsu_wr    = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        retire    = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (start) nxt_state = S_FETCH;
            end
            S_FETCH: begin
                ifu_req = 1'b1;
                if (ifu_gnt)              nxt_state = S_WAIT_I;
                else if (tmo == TIMEOUT)  nxt_state = S_ERROR;
            end
            S_WAIT_I: begin
                if (ifu_rvalid) begin
                    ir_we     = 1'b1;
                    nxt_state = S_DECODE;
                end else if (tmo == TIMEOUT) begin
                    nxt_state = S_ERROR;
                end
            end
            S_DECODE: begin
                if (inst_opcode == OP_SYSTEM) begin
                    nxt_state = S_HALT;
                    retire    = 1'b1;
                end else if (!opcode_ok) begin
                    nxt_state = S_ERROR;
                end else if ((read_mem != 3'd0) || (write_mem != 2'd0)) begin
                    nxt_state = S_MEM;
                end else begin
                    nxt_state = S_WB;
                end
            end
            S_MEM: begin
                lsu_req = 1'b1;
                lsu_wr  = (write_mem != 2'd0);
                if (lsu_gnt)              nxt_state = S_WAIT_D;
                else if (tmo == TIMEOUT)  nxt_state = S_ERROR;
            end
            S_WAIT_D: begin
                if (lsu_rvalid)           nxt_state = S_WB;
                else if (tmo == TIMEOUT)  nxt_state = S_ERROR;
            end
            S_WB: begin
                rf_we     = write_reg;
                pc_we     = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_HALT:  nxt_state = S_HALT;
            S_ERROR: nxt_state = S_ERROR;
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
            tmo       <= '0;
            cycle_cnt <= '0;
            instret   <= '0;
            halted    <= 1'b0;
            error     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            // Timeout restarts on every state change so each handshake state starts at zero.
            if (nxt_state != cur_state) tmo <= '0;
            else if (in_wait)           tmo <= tmo + TW'(1);
            if (active) cycle_cnt <= cycle_cnt + CW'(1);
            if (retire) instret   <= instret + CW'(1);
            if (nxt_state == S_HALT)  halted <= 1'b1;
            if (nxt_state == S_ERROR) error  <= 1'b1;
        end
    end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter: TIMEOUT, default 8'd255, maximum cycles spent waiting in any handshake state before an error is raised.
REQ-002 clk  input  1  single core clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  leave IDLE and begin fetching.
REQ-005 inst_opcode  input  7  opcode field of the latched instruction register (IR).
REQ-006 read_mem  input  3  decoder load code; nonzero means a load.
REQ-007 write_mem  input  2  decoder store code; nonzero means a store.
REQ-008 write_reg  input  1  decoder register-writeback enable.
REQ-009 ifu_req  output  1  instruction fetch request.
REQ-010 ifu_gnt  input  1  fetch accepted.
REQ-011 ifu_rvalid  input  1  fetched instruction valid.
REQ-012 ir_we  output  1  latch instruction into IR.
REQ-013 lsu_req / lsu_wr  output  1 / 1  data memory request and write qualifier.
REQ-014 lsu_gnt / lsu_rvalid  input  1 / 1  data request accepted / load data or store acknowledge.
REQ-015 rf_we / pc_we  output  1 / 1  register-file write strobe and PC update strobe.
REQ-016 halted / error  output  1 / 1  sticky status flags.
REQ-017 state  output  4  current FSM state.
REQ-018 cycle_cnt / instret  output  64 / 64  active-cycle and retired-instruction counters.

Function
REQ-019 State encoding: IDLE=0, FETCH=1, WAIT_I=2, DECODE=3, MEM=4, WAIT_D=5, WB=6, HALT=7, ERROR=8.
REQ-020 IDLE: all strobes 0; start=1 -> FETCH.
REQ-021 FETCH: ifu_req=1, held until ifu_gnt=1 is seen with ifu_req=1; that cycle -> WAIT_I.
REQ-022 WAIT_I: ifu_rvalid=1 -> ir_we=1 for that cycle, -> DECODE; ifu_rvalid outside WAIT_I is ignored.
REQ-023 DECODE: one cycle; priority order: opcode 1110011 -> HALT; opcode not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011} -> ERROR; read_mem!=0 or write_mem!=0 -> MEM; otherwise -> WB.
REQ-024 MEM: lsu_req=1, lsu_wr=(write_mem!=0), held until lsu_gnt=1; that cycle -> WAIT_D.
REQ-025 WAIT_D: lsu_rvalid=1 -> WB; lsu_rvalid outside WAIT_D is ignored.
REQ-026 WB: one cycle; rf_we=write_reg, pc_we=1, instret+1; -> FETCH.
REQ-027 HALT: entered from DECODE with instret+1 on the transition; halted=1; no requests; remains until reset.
REQ-028 ERROR: error=1; no requests, no strobes; remains until reset; instret not incremented.
REQ-029 Timeout counter: cleared on entry to FETCH, WAIT_I, MEM or WAIT_D; +1 each cycle in those states; counter==TIMEOUT with no handshake that cycle -> ERROR; a handshake in that same cycle wins.
REQ-030 cycle_cnt +1 every cycle state is not IDLE, HALT or ERROR; cycle_cnt and instret wrap modulo 2^64.
REQ-031 ir_we, rf_we and pc_we are single-cycle pulses, at most one of each per instruction.
REQ-032 Minimum latency with gnt in the request cycle and rvalid the following cycle: 4 cycles for a non-memory instruction and 6 cycles for a load or store, measured from the first FETCH cycle through WB inclusive.
REQ-033 Decode inputs are sampled only in DECODE, MEM and WB.

Reset
REQ-034 rst_n=0 immediately forces state=IDLE, all outputs 0, cycle_cnt=0, instret=0, timeout counter=0, halted=0, error=0, from any state including mid-handshake.
REQ-035 After reset, responses to requests issued before reset are ignored, because IDLE ignores gnt and rvalid.

Verification
REQ-036 Reset; start; opcode 0010011, write_reg=1, ifu_gnt in the request cycle, ifu_rvalid next -> ir_we in cycle 2; rf_we=pc_we=1 in cycle 4; instret=1; state back to FETCH.
REQ-037 Load, read_mem=001, lsu_gnt delayed 3 cycles -> lsu_req=1 with lsu_wr=0 for 4 cycles; WB one cycle after lsu_rvalid; rf_we=1.
REQ-038 Store, write_mem=01, write_reg=0 -> lsu_wr=1; WB has rf_we=0, pc_we=1.
REQ-039 Opcode 1110011 -> HALT; halted=1; instret increments by 1; cycle_cnt freezes; no further ifu_req. Opcode 0000000 -> ERROR; error=1; instret unchanged.
REQ-040 TIMEOUT=4, ifu_gnt held 0 -> ifu_req high 5 cycles, then ERROR. Same setup with ifu_gnt on the 5th cycle -> WAIT_I, no error.
REQ-041 rst_n pulsed low in WAIT_D -> state=0 and counters 0 at once; late lsu_rvalid after release has no effect.
